// File: rtl/calc_sequencer.sv
`timescale 1ns/1ps
// calc_sequencer: steps the row multiplier through one classification pass,
// writes every row result to the result store and reports the arg-max row.
// Optional per-row watchdog: define CALC_WATCHDOG_EN.
module calc_sequencer #(
    parameter int NUM_ROWS = 10,
    parameter int RES_W    = 16,
    parameter int WDOG_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_calc,
    input  logic                    abort,
    input  logic                    done_row,
    input  logic signed [RES_W-1:0] row_result,
    output logic [3:0]              row_select,
    output logic                    begin_mult,
    output logic                    res_wen,
    output logic [3:0]              res_addr,
    output logic signed [RES_W:0]   res_data,
    output logic                    busy,
    output logic                    done_calc,
    output logic [3:0]              best_class,
    output logic                    best_valid,
    output logic                    wdog_err
);
    localparam logic [3:0] LAST_ROW = 4'(NUM_ROWS - 1);

    if (NUM_ROWS < 2 || NUM_ROWS > 16) begin : g_bad_rows
        $error("calc_sequencer: NUM_ROWS must be within 2..16");
    end
    if (WDOG_CYC < 1) begin : g_bad_wdog
        $error("calc_sequencer: WDOG_CYC must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_STORE,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [3:0]              row_q;
    logic [3:0]              argmax_q;
    logic signed [RES_W-1:0] max_q;
    logic                    begin_mult_q;
    logic                    res_wen_q;
    logic signed [RES_W:0]   res_data_q;
    logic                    busy_q;
    logic                    done_calc_q;
    logic [3:0]              best_class_q;
    logic                    best_valid_q;

`ifdef CALC_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    logic [WD_W-1:0] wdog_cnt_q;
    logic            wdog_err_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            argmax_q     <= '0;
            max_q        <= '0;
            begin_mult_q <= 1'b0;
            res_wen_q    <= 1'b0;
            res_data_q   <= '0;
            busy_q       <= 1'b0;
            done_calc_q  <= 1'b0;
            best_class_q <= '0;
            best_valid_q <= 1'b0;
`ifdef CALC_WATCHDOG_EN
            wdog_cnt_q   <= '0;
            wdog_err_q   <= 1'b0;
`endif
        end else begin
            begin_mult_q <= 1'b0;
            res_wen_q    <= 1'b0;
            done_calc_q  <= 1'b0;
            // abort outranks everything, including a done_row that would have stored
            if (abort) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_calc) begin
                            state_q      <= S_LAUNCH;
                            row_q        <= '0;
                            best_valid_q <= 1'b0;
                            busy_q       <= 1'b1;
                            begin_mult_q <= 1'b1;
`ifdef CALC_WATCHDOG_EN
                            wdog_err_q   <= 1'b0;
`endif
                        end
                    end
                    S_LAUNCH: begin
                        state_q <= S_WAIT;
`ifdef CALC_WATCHDOG_EN
                        wdog_cnt_q <= '0;
`endif
                    end
                    S_WAIT: begin
                        if (done_row) begin
                            state_q    <= S_STORE;
                            res_wen_q  <= 1'b1;
                            res_data_q <= {row_result[RES_W-1], row_result};
                            // strict compare so ties keep the lower row index
                            if (row_q == 4'd0 || row_result > max_q) begin
                                max_q    <= row_result;
                                argmax_q <= row_q;
                            end
                        end
`ifdef CALC_WATCHDOG_EN
                        else if (wdog_cnt_q == WD_W'(WDOG_CYC - 1)) begin
                            state_q    <= S_IDLE;
                            busy_q     <= 1'b0;
                            wdog_err_q <= 1'b1;
                        end else begin
                            wdog_cnt_q <= wdog_cnt_q + WD_W'(1);
                        end
`endif
                    end
                    S_STORE: begin
                        if (row_q == LAST_ROW) begin
                            state_q      <= S_DONE;
                            done_calc_q  <= 1'b1;
                            best_valid_q <= 1'b1;
                            best_class_q <= argmax_q;
                        end else begin
                            state_q      <= S_LAUNCH;
                            row_q        <= row_q + 4'd1;
                            begin_mult_q <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign row_select = row_q;
    assign res_addr   = row_q;
    assign begin_mult = begin_mult_q;
    assign res_wen    = res_wen_q;
    assign res_data   = res_data_q;
    assign busy       = busy_q;
    assign done_calc  = done_calc_q;
    assign best_class = best_class_q;
    assign best_valid = best_valid_q;
`ifdef CALC_WATCHDOG_EN
    assign wdog_err   = wdog_err_q;
`else
    assign wdog_err   = 1'b0;
`endif

endmodule

// File: tb/tb_calc_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for calc_sequencer: a multiplier model answers begin_mult,
// expected writes and pass results are queued at start and checked by a monitor.
module tb_calc_sequencer;
    localparam int NUM_ROWS = 10;
    localparam int RES_W    = 16;
    localparam int WDOG_CYC = 16;

    logic clk = 1'b0;
    logic rst, start_calc, abort, done_m, spur_done, done_row;
    logic signed [RES_W-1:0] res_m;
    logic [3:0] row_select, res_addr, best_class;
    logic begin_mult, res_wen, busy, done_calc, best_valid, wdog_err;
    logic signed [RES_W:0] res_data;

    assign done_row = done_m | spur_done;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    calc_sequencer #(.NUM_ROWS(NUM_ROWS), .RES_W(RES_W), .WDOG_CYC(WDOG_CYC)) dut (
        .clk(clk), .rst(rst), .start_calc(start_calc), .abort(abort),
        .done_row(done_row), .row_result(res_m), .row_select(row_select),
        .begin_mult(begin_mult), .res_wen(res_wen), .res_addr(res_addr),
        .res_data(res_data), .busy(busy), .done_calc(done_calc),
        .best_class(best_class), .best_valid(best_valid), .wdog_err(wdog_err)
    );

    int res_tab[NUM_ROWS];
    int k_tab[NUM_ROWS];
    bit hold_tab[NUM_ROWS];

    int wq_addr[$];
    int wq_data[$];
    int dq_best[$];
    int dq_cyc[$];
    int n_pass = 0;
    int n_total = 0;
    int pass_cnt = 0;
    int exp_passes = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    task automatic note_fail(input string name, input longint act);
        n_total++;
        $display("FAIL %s: got %0d, required none", name, act);
    endtask

    // Multiplier model: answers k_tab[row] cycles after begin_mult unless held.
    initial begin
        int r;
        done_m = 1'b0;
        res_m  = '0;
        forever begin
            @(negedge clk);
            if (begin_mult) begin
                r = int'(row_select);
                repeat (k_tab[r]) @(posedge clk);
                #1;
                if (!hold_tab[r]) begin
                    done_m = 1'b1;
                    res_m  = 16'(res_tab[r]);
                end
                @(posedge clk);
                #1 done_m = 1'b0;
            end
        end
    end

    // Monitor: every write and every done_calc must match a queued expectation.
    initial begin
        int ea, ed, eb, ec;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (res_wen) begin
                    if (wq_addr.size() == 0) note_fail("unexpected_write", res_addr);
                    else begin
                        ea = wq_addr.pop_front();
                        ed = wq_data.pop_front();
                        check("wr_addr", res_addr, ea);
                        check("wr_data", res_data, ed);
                    end
                end
                if (done_calc) begin
                    pass_cnt++;
                    if (dq_best.size() == 0) note_fail("unexpected_done", best_class);
                    else begin
                        eb = dq_best.pop_front();
                        ec = dq_cyc.pop_front();
                        check("best_class", best_class, eb);
                        check("best_valid_at_done", best_valid, 1);
                        check("busy_at_done", busy, 1);
                        check("pass_latency_cycle", cyc, ec);
                    end
                end
            end
        end
    end

    // Reference: writes are rows 0..n-1 in order; arg-max is the first maximum.
    task automatic expect_pass(input int n_writes, input bit with_done);
        int best, lat;
        for (int r = 0; r < n_writes; r++) begin
            wq_addr.push_back(r);
            wq_data.push_back(res_tab[r]);
        end
        if (with_done) begin
            best = 0;
            lat  = 1;
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (res_tab[r] > res_tab[best]) best = r;
                lat += k_tab[r] + 2;
            end
            dq_best.push_back(best);
            dq_cyc.push_back(cyc + lat);
            exp_passes++;
        end
    endtask

    task automatic do_start(input int n_writes, input bit with_done);
        @(negedge clk);
        start_calc = 1'b1;
        expect_pass(n_writes, with_done);
        @(negedge clk);
        start_calc = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy) note_fail("timeout_idle", n);
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_launch(input int row);
        int n = 0;
        while (!(begin_mult && row_select == 4'(row)) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) note_fail("timeout_launch", row);
    endtask

    task automatic fill(input int lo, input int hi, input int kmin, input int kmax);
        for (int r = 0; r < NUM_ROWS; r++) begin
            res_tab[r]  = lo + int'($urandom_range(0, hi - lo));
            k_tab[r]    = int'($urandom_range(kmin, kmax));
            hold_tab[r] = 1'b0;
        end
    endtask

    initial begin
        int pc;
        int n;
        rst = 1'b1;
        start_calc = 1'b0;
        abort = 1'b0;
        spur_done = 1'b0;
        fill(0, 0, 3, 3);
        repeat (3) @(negedge clk);
        check("reset_outputs", {row_select, begin_mult, res_wen, res_addr, res_data, busy,
                                done_calc, best_class, best_valid, wdog_err}, 0);
        check("reset_best_valid", best_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // nominal pass
        res_tab = '{5, -2, 9, 9, 0, 1, -7, 3, 8, 4};
        do_start(10, 1);
        wait_idle();
        check("nominal_best_class", best_class, 2);
        check("nominal_best_valid", best_valid, 1);
        check("nominal_pass_count", pass_cnt, 1);

        // all negative results
        for (int r = 0; r < NUM_ROWS; r++) res_tab[r] = -91 - r;
        do_start(10, 1);
        n = 0;
        while (!res_wen && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("neg_row0_raw", longint'($unsigned(res_data)), 'h1FFA5);
        wait_idle();
        check("neg_best_class", best_class, 0);

        // random passes: full range, then narrow range to force ties
        for (int p = 0; p < 4; p++) begin
            if (p < 2) fill(-32768, 32767, 1, 4);
            else fill(-2, 2, 1, 4);
            do_start(10, 1);
            wait_idle();
        end

        // abort during WAIT of row 4
        fill(-50, 50, 3, 3);
        pc = pass_cnt;
        do_start(4, 0);
        wait_launch(4);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        check("abort_idle", busy, 0);
        abort = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_best_valid", best_valid, 0);
        check("abort_no_done", pass_cnt, pc);

        // abort wins over start in IDLE
        @(negedge clk);
        abort = 1'b1;
        start_calc = 1'b1;
        @(negedge clk);
        check("abort_start_idle", busy, 0);
        abort = 1'b0;
        start_calc = 1'b0;
        @(negedge clk);
        check("abort_start_no_launch", busy, 0);

        // spurious done_row in IDLE and LAUNCH, start pulses while busy
        @(negedge clk);
        spur_done = 1'b1;
        repeat (3) @(negedge clk);
        spur_done = 1'b0;
        check("spur_idle_busy", busy, 0);
        fill(-1000, 1000, 2, 4);
        pc = pass_cnt;
        @(negedge clk);
        start_calc = 1'b1;
        expect_pass(10, 1);
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        start_calc = 1'b0;
        repeat (6) @(negedge clk);
        start_calc = 1'b1;
        @(negedge clk);
        start_calc = 1'b0;
        wait_idle();
        check("spur_pass_count", pass_cnt, pc + 1);
        check("spur_no_restart", busy, 0);

        // asynchronous reset during STORE of row 7
        fill(-300, 300, 1, 3);
        do_start(8, 0);
        n = 0;
        while (!(res_wen && res_addr == 4'd7) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) note_fail("timeout_row7", n);
        #2 rst = 1'b1;
        #1;
        check("async_rst_outputs", {row_select, begin_mult, res_wen, res_addr, res_data, busy,
                                    done_calc, best_class, best_valid, wdog_err}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_idle_busy", busy, 0);

        // recovery pass after reset
        fill(-32768, 32767, 1, 4);
        do_start(10, 1);
        wait_idle();

`ifdef CALC_WATCHDOG_EN
        // watchdog trips on a withheld row 2
        fill(-20, 20, 2, 2);
        hold_tab[2] = 1'b1;
        do_start(2, 0);
        wait_launch(2);
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            if (i == 15) begin
                check("wdog_quiet", wdog_err, 0);
                check("wdog_busy", busy, 1);
            end
            if (i == 17) begin
                check("wdog_err_set", wdog_err, 1);
                check("wdog_idle", busy, 0);
            end
        end
        hold_tab[2] = 1'b0;
        repeat (4) @(negedge clk);
        do_start(10, 1);
        check("wdog_err_cleared", wdog_err, 0);
        wait_idle();
`endif

        check("final_wdog_err", wdog_err, 0);
        check("final_pass_count", pass_cnt, exp_passes);
        check("writes_drained", wq_addr.size(), 0);
        check("dones_drained", dq_best.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
